// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - loads operands A, B and opcode from a byte stream, then starts the ALU
// Optional idle timeout in GET_B/GET_OP compiled in with OPERAND_LOADER_TIMEOUT_EN.
module operand_loader (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] reg_data,
   output logic       load_a,
   output logic       load_b,
   output logic       load_op,
   output logic       start,
   input  logic       alu_done,
   output logic       busy,
   output logic [7:0] frame_count,
   output logic       timeout
);

   typedef enum logic [2:0] {
      ST_GET_A,
      ST_GET_B,
      ST_GET_OP,
      ST_SETTLE,
      ST_START,
      ST_WAIT_DONE
   } state_t;

   state_t     r_state;
   logic [7:0] r_data;
   logic       r_load_a;
   logic       r_load_b;
   logic       r_load_op;
   logic [7:0] r_frame_count;
   logic       r_timeout;

   logic       w_in_ready;
   logic       w_accept;
   logic       w_waiting;
   logic       w_idle_expire;

   assign w_in_ready = (r_state == ST_GET_A) || (r_state == ST_GET_B) || (r_state == ST_GET_OP);
   assign w_accept   = in_valid && w_in_ready;
   assign w_waiting  = (r_state == ST_GET_B) || (r_state == ST_GET_OP);

`ifdef OPERAND_LOADER_TIMEOUT_EN
   logic [7:0] r_idle;

   // The 255th consecutive idle cycle abandons the frame; a byte arriving on that cycle wins.
   assign w_idle_expire = w_waiting && !w_accept && (r_idle == 8'd254);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idle <= 8'd0;
      end else if (w_accept || !w_waiting || w_idle_expire) begin
         r_idle <= 8'd0;
      end else begin
         r_idle <= r_idle + 8'd1;
      end
   end
`else
   assign w_idle_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_GET_A;
         r_data        <= 8'd0;
         r_load_a      <= 1'b0;
         r_load_b      <= 1'b0;
         r_load_op     <= 1'b0;
         r_frame_count <= 8'd0;
         r_timeout     <= 1'b0;
      end else begin
         r_load_a  <= 1'b0;
         r_load_b  <= 1'b0;
         r_load_op <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            ST_GET_A: begin
               if (w_accept) begin
                  r_data   <= in_data;
                  r_load_a <= 1'b1;
                  r_state  <= ST_GET_B;
               end
            end
            ST_GET_B: begin
               if (w_accept) begin
                  r_data   <= in_data;
                  r_load_b <= 1'b1;
                  r_state  <= ST_GET_OP;
               end else if (w_idle_expire) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_GET_A;
               end
            end
            ST_GET_OP: begin
               if (w_accept) begin
                  r_data    <= in_data;
                  r_load_op <= 1'b1;
                  r_state   <= ST_SETTLE;
               end else if (w_idle_expire) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_GET_A;
               end
            end
            // One cycle gap so the OP register holds the opcode before start is seen.
            ST_SETTLE: r_state <= ST_START;
            ST_START: begin
               r_frame_count <= r_frame_count + 8'd1;
               r_state       <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (alu_done) begin
                  r_state <= ST_GET_A;
               end
            end
            default: r_state <= ST_GET_A;
         endcase
      end
   end

   assign in_ready    = w_in_ready;
   assign reg_data    = r_data;
   assign load_a      = r_load_a;
   assign load_b      = r_load_b;
   assign load_op     = r_load_op;
   assign start       = (r_state == ST_START);
   assign busy        = (r_state != ST_GET_A);
   assign frame_count = r_frame_count;
   assign timeout     = r_timeout;

endmodule
